// File: rtl/eq_scan_unit_16b_if.sv
// -----------------------------------------------------------------------------
// eq_scan_unit_16b_if
//   Bundles the command, input stream and response signals of the equality
//   scanner so that producer/consumer and scanner connect through one port.
//
//   Command  : start, key, len          (master -> slave), busy (slave -> master)
//   Istream  : istream_val, istream_data (master -> slave), istream_rdy (back)
//   Response : resp_val, found, first_idx, match_cnt (slave -> master),
//              resp_rdy (master -> slave)
// -----------------------------------------------------------------------------
interface eq_scan_unit_16b_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [15:0]      key;
    logic [LEN_W-1:0] len;
    logic             busy;

    logic             istream_val;
    logic             istream_rdy;
    logic [15:0]      istream_data;

    logic             resp_val;
    logic             resp_rdy;
    logic             found;
    logic [LEN_W-1:0] first_idx;
    logic [LEN_W-1:0] match_cnt;

    // Driver side: issues commands, produces words, consumes results.
    modport master (
        output start, key, len, istream_val, istream_data, resp_rdy,
        input  busy, istream_rdy, resp_val, found, first_idx, match_cnt
    );

    // Scanner side.
    modport slave (
        input  start, key, len, istream_val, istream_data, resp_rdy,
        output busy, istream_rdy, resp_val, found, first_idx, match_cnt
    );
endinterface

// File: rtl/eq_scan_unit_16b.sv
// -----------------------------------------------------------------------------
// eq_scan_unit_16b
//   Multi-cycle equality scanner. On start (IDLE only) it latches a 16-bit key
//   and a word count, then consumes that many words from a val/rdy stream,
//   comparing each against the key. The result (any match, index of the first
//   match, number of matches) is offered on a val/rdy response channel.
//
//   Ports
//     clk      : rising-edge clock
//     rst      : asynchronous, active-high reset; aborts any scan in flight
//     scan_if  : eq_scan_unit_16b_if.slave (command, input stream, response)
// -----------------------------------------------------------------------------
module eq_scan_unit_16b #(
    parameter int LEN_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    eq_scan_unit_16b_if.slave     scan_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [15:0]      key_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx_q;
    logic             found_q;
    logic [LEN_W-1:0] first_idx_q;
    logic [LEN_W-1:0] match_cnt_q;

    logic             xfer;
    logic             eq;
    logic             last_word;
    logic [LEN_W-1:0] idx_d;
    logic [LEN_W-1:0] match_cnt_d;

    // A word moves only while scanning; rdy is a pure decode of the state.
    assign xfer        = (state_q == SCAN) && scan_if.istream_val;
    assign eq          = (scan_if.istream_data == key_q);
    // len_q is never 0 in SCAN, so len_q-1 cannot wrap here.
    assign last_word   = (idx_q == len_q - LEN_W'(1));
    assign idx_d       = idx_q + LEN_W'(1);
    assign match_cnt_d = match_cnt_q + LEN_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            key_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            found_q     <= 1'b0;
            first_idx_q <= '0;
            match_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (scan_if.start) begin
                        key_q       <= scan_if.key;
                        len_q       <= scan_if.len;
                        idx_q       <= '0;
                        found_q     <= 1'b0;
                        first_idx_q <= '0;
                        match_cnt_q <= '0;
                        // A zero-length scan reports an empty result at once.
                        state_q     <= (scan_if.len != '0) ? SCAN : DONE;
                    end
                end
                SCAN: begin
                    if (xfer) begin
                        if (eq) begin
                            // Only the first hit records its position.
                            if (!found_q) begin
                                first_idx_q <= idx_q;
                            end
                            found_q     <= 1'b1;
                            match_cnt_q <= match_cnt_d;
                        end
                        idx_q <= idx_d;
                        if (last_word) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Result registers are left untouched so they stay
                    // readable until the next start.
                    if (scan_if.resp_rdy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign scan_if.busy        = (state_q != IDLE);
    assign scan_if.istream_rdy = (state_q == SCAN);
    assign scan_if.resp_val    = (state_q == DONE);
    assign scan_if.found       = found_q;
    assign scan_if.first_idx   = first_idx_q;
    assign scan_if.match_cnt   = match_cnt_q;

endmodule
